// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N:1 AXI4 read arbiter with round-robin AR grant, ID widening and R routing by index
module axi_rd_arbiter #(
  parameter int NUM_M      = 2,
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int BYTE_WIDTH = 32,
  parameter int MAX_OUTST  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_M*ID_WIDTH-1:0]         s_arid,
  input  logic [NUM_M*ADDR_WIDTH-1:0]       s_araddr,
  input  logic [NUM_M*8-1:0]                s_arlen,
  input  logic [NUM_M*3-1:0]                s_arsize,
  input  logic [NUM_M*2-1:0]                s_arburst,
  input  logic [NUM_M*15-1:0]               s_arattr,
  input  logic [NUM_M-1:0]                  s_arvalid,
  output logic [NUM_M-1:0]                  s_arready,
  output logic [NUM_M*ID_WIDTH-1:0]         s_rid,
  output logic [NUM_M*BYTE_WIDTH*8-1:0]     s_rdata,
  output logic [NUM_M*2-1:0]                s_rresp,
  output logic [NUM_M-1:0]                  s_rlast,
  output logic [NUM_M-1:0]                  s_rvalid,
  input  logic [NUM_M-1:0]                  s_rready,
  output logic [ID_WIDTH+$clog2(NUM_M)-1:0] m_arid,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [7:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic [14:0]                       m_arattr,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic [ID_WIDTH+$clog2(NUM_M)-1:0] m_rid,
  input  logic [BYTE_WIDTH*8-1:0]           m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  output logic                              err_rid
);
  localparam int IDX_W = $clog2(NUM_M);
  localparam int CNT_W = $clog2(MAX_OUTST+1);
  localparam int MID_W = ID_WIDTH+IDX_W;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, rr_q, rr_d, win, ridx;
  logic [CNT_W-1:0] outst_q [NUM_M];
  logic [CNT_W-1:0] outst_d [NUM_M];
  logic [NUM_M-1:0] elig, ar_hs, r_done;
  logic ar_fire, rid_hit, err_q;
  assign ridx      = m_rid[MID_W-1 -: IDX_W];
  assign m_arid    = {grant_q, s_arid[grant_q*ID_WIDTH +: ID_WIDTH]};
  assign m_araddr  = s_araddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_arlen   = s_arlen[grant_q*8 +: 8];
  assign m_arsize  = s_arsize[grant_q*3 +: 3];
  assign m_arburst = s_arburst[grant_q*2 +: 2];
  assign m_arattr  = s_arattr[grant_q*15 +: 15];
  assign m_arvalid = (state_q == BUSY) && s_arvalid[grant_q];
  assign ar_fire   = m_arvalid && m_arready;
  assign s_rid     = {NUM_M{m_rid[ID_WIDTH-1:0]}};
  assign s_rdata   = {NUM_M{m_rdata}};
  assign s_rresp   = {NUM_M{m_rresp}};
  assign s_rlast   = {NUM_M{m_rlast}};
  assign err_rid   = err_q;
  // second pass overrides the first, so a candidate at/after rr_ptr wins over a wrapped one
  always_comb begin
    win = rr_q;
    for (int i = 0; i < NUM_M; i++) elig[i] = s_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
    for (int j = NUM_M-1; j >= 0; j--) if (elig[j]) win = IDX_W'(j);
    for (int j = NUM_M-1; j >= 0; j--) if (elig[j] && IDX_W'(j) >= rr_q) win = IDX_W'(j);
  end
  // out-of-range R index leaves rid_hit low: the beat is sunk with m_rready=1
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b1;
    rid_hit   = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      s_arready[i] = (state_q == BUSY) && (grant_q == IDX_W'(i)) && m_arready;
      ar_hs[i]     = ar_fire && (grant_q == IDX_W'(i));
      r_done[i]    = (ridx == IDX_W'(i)) && m_rvalid && s_rready[i] && m_rlast;
      outst_d[i]   = outst_q[i] + CNT_W'(ar_hs[i]) - CNT_W'(r_done[i]);
      if (ridx == IDX_W'(i)) begin
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
        rid_hit     = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    if (state_q == IDLE && |elig) begin
      state_d = BUSY;
      grant_d = win;
    end
    if (ar_fire) begin
      state_d = IDLE;
      rr_d    = (grant_q == IDX_W'(NUM_M-1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      outst_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_q | (m_rvalid && !rid_hit);
      outst_q <= outst_d;
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of arbitration, throttling, R routing and reset for axi_rd_arbiter
module tb_axi_rd_arbiter;
  logic clk = 1'b0, rst, rstb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  logic [31:0]  a_s_arid;
  logic [127:0] a_s_araddr;
  logic [15:0]  a_s_arlen;
  logic [5:0]   a_s_arsize;
  logic [3:0]   a_s_arburst;
  logic [29:0]  a_s_arattr;
  logic [1:0]   a_s_arvalid, a_s_arready, a_s_rlast, a_s_rvalid, a_s_rready;
  logic [31:0]  a_s_rid;
  logic [511:0] a_s_rdata;
  logic [3:0]   a_s_rresp;
  logic [16:0]  a_m_arid, a_m_rid;
  logic [63:0]  a_m_araddr;
  logic [7:0]   a_m_arlen;
  logic [2:0]   a_m_arsize;
  logic [1:0]   a_m_arburst, a_m_rresp;
  logic [14:0]  a_m_arattr;
  logic [255:0] a_m_rdata;
  logic a_m_arvalid, a_m_arready, a_m_rlast, a_m_rvalid, a_m_rready, a_err;
  logic [47:0]  b_s_arid, b_s_rid;
  logic [191:0] b_s_araddr;
  logic [23:0]  b_s_arlen;
  logic [8:0]   b_s_arsize;
  logic [5:0]   b_s_arburst, b_s_rresp;
  logic [44:0]  b_s_arattr;
  logic [2:0]   b_s_arvalid, b_s_arready, b_s_rlast, b_s_rvalid, b_s_rready;
  logic [767:0] b_s_rdata;
  logic [17:0]  b_m_arid, b_m_rid;
  logic [63:0]  b_m_araddr;
  logic [7:0]   b_m_arlen;
  logic [2:0]   b_m_arsize;
  logic [1:0]   b_m_arburst, b_m_rresp;
  logic [14:0]  b_m_arattr;
  logic [255:0] b_m_rdata;
  logic b_m_arvalid, b_m_arready, b_m_rlast, b_m_rvalid, b_m_rready, b_err;
  axi_rd_arbiter #(.NUM_M(2)) dut_a (
    .clk(clk), .rst(rst), .s_arid(a_s_arid), .s_araddr(a_s_araddr), .s_arlen(a_s_arlen),
    .s_arsize(a_s_arsize), .s_arburst(a_s_arburst), .s_arattr(a_s_arattr), .s_arvalid(a_s_arvalid),
    .s_arready(a_s_arready), .s_rid(a_s_rid), .s_rdata(a_s_rdata), .s_rresp(a_s_rresp),
    .s_rlast(a_s_rlast), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready), .m_arid(a_m_arid),
    .m_araddr(a_m_araddr), .m_arlen(a_m_arlen), .m_arsize(a_m_arsize), .m_arburst(a_m_arburst),
    .m_arattr(a_m_arattr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready), .m_rid(a_m_rid),
    .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rlast(a_m_rlast), .m_rvalid(a_m_rvalid),
    .m_rready(a_m_rready), .err_rid(a_err));
  axi_rd_arbiter #(.NUM_M(3)) dut_b (
    .clk(clk), .rst(rstb), .s_arid(b_s_arid), .s_araddr(b_s_araddr), .s_arlen(b_s_arlen),
    .s_arsize(b_s_arsize), .s_arburst(b_s_arburst), .s_arattr(b_s_arattr), .s_arvalid(b_s_arvalid),
    .s_arready(b_s_arready), .s_rid(b_s_rid), .s_rdata(b_s_rdata), .s_rresp(b_s_rresp),
    .s_rlast(b_s_rlast), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready), .m_arid(b_m_arid),
    .m_araddr(b_m_araddr), .m_arlen(b_m_arlen), .m_arsize(b_m_arsize), .m_arburst(b_m_arburst),
    .m_arattr(b_m_arattr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_rid(b_m_rid),
    .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rlast(b_m_rlast), .m_rvalid(b_m_rvalid),
    .m_rready(b_m_rready), .err_rid(b_err));
  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int beats;
    rst = 1'b1; rstb = 1'b1;
    a_s_arid = {16'h0077, 16'h0005}; a_s_araddr = {64'h2000, 64'h1000};
    a_s_arlen = 16'h0303; a_s_arsize = 6'b101_101; a_s_arburst = 4'b0101; a_s_arattr = '0;
    a_s_arvalid = '0; a_s_rready = '0; a_m_arready = 1'b0; a_m_rid = '0; a_m_rdata = '0;
    a_m_rresp = '0; a_m_rlast = 1'b0; a_m_rvalid = 1'b0;
    b_s_arid = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0; b_s_arburst = '0;
    b_s_arattr = '0; b_s_arvalid = '0; b_s_rready = '0; b_m_arready = 1'b0; b_m_rid = '0;
    b_m_rdata = '0; b_m_rresp = '0; b_m_rlast = 1'b0; b_m_rvalid = 1'b0;
    #3;
    chk("rst_arvalid", a_m_arvalid, 0);
    chk("rst_arready", a_s_arready, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rstb = 1'b0;
    chk("post_rst_arvalid", a_m_arvalid, 0);
    a_s_arvalid = 2'b01;
    #1 chk("t1_same_cycle", a_m_arvalid, 0);
    step();
    chk("t1_arvalid", a_m_arvalid, 1);
    chk("t1_arid", a_m_arid, 17'h00005);
    chk("t1_araddr", a_m_araddr, 64'h1000);
    chk("t1_arready_wait", a_s_arready, 2'b00);
    a_m_arready = 1'b1;
    #1 chk("t1_arready", a_s_arready, 2'b01);
    step();
    chk("t1_idle", a_m_arvalid, 0);
    a_s_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_valid", a_m_arvalid, 1);
      chk("t2_grant", a_m_arid[16], (k % 2 == 0) ? 1 : 0);
      chk("t2_arid", a_m_arid[15:0], (k % 2 == 0) ? 16'h77 : 16'h5);
      chk("t2_araddr", a_m_araddr, (k % 2 == 0) ? 64'h2000 : 64'h1000);
      chk("t2_arready", a_s_arready, (k % 2 == 0) ? 2'b10 : 2'b01);
      step();
      chk("t2_gap", a_m_arvalid, 0);
    end
    a_s_arvalid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_fill", {a_m_arvalid, a_m_arid[16]}, 2'b10);
      step();
    end
    step();
    chk("t3_block1", a_m_arvalid, 0);
    step();
    chk("t3_block2", a_m_arvalid, 0);
    a_s_arvalid = 2'b11;
    step();
    chk("t3_m1_served", {a_m_arvalid, a_m_arid[16]}, 2'b11);
    step();
    a_s_arvalid = 2'b01;
    a_m_rid = '0; a_m_rvalid = 1'b1; a_m_rlast = 1'b1; a_s_rready = 2'b01;
    #1 chk("t3_rready", a_m_rready, 1);
    step();
    a_m_rvalid = 1'b0;
    step();
    chk("t3_regrant", {a_m_arvalid, a_m_arid[16]}, 2'b10);
    a_m_rvalid = 1'b1;
    step();
    a_m_rvalid = 1'b0;
    chk("t5_idle", a_m_arvalid, 0);
    step();
    chk("t5_again", {a_m_arvalid, a_m_arid[16]}, 2'b10);
    step();
    step();
    chk("t5_full1", a_m_arvalid, 0);
    step();
    chk("t5_full2", a_m_arvalid, 0);
    a_s_arvalid = 2'b00; a_m_arready = 1'b0;
    a_m_rid = {1'b1, 16'h0003}; a_m_rvalid = 1'b1; beats = 0;
    for (int i = 0; i < 8; i++) begin
      a_s_rready = (i % 2 == 1) ? 2'b10 : 2'b00;
      a_m_rlast = (beats == 3);
      a_m_rdata = 256'(i + 100);
      #1;
      chk("t4_rvalid", a_s_rvalid, 2'b10);
      chk("t4_rid", a_s_rid[31:16], 16'h3);
      chk("t4_rready", a_m_rready, (i % 2 == 1) ? 1 : 0);
      chk("t4_rdata", a_s_rdata[511:256], 256'(i + 100));
      if (i % 2 == 1) beats++;
      step();
    end
    a_m_rvalid = 1'b0; a_m_rlast = 1'b0; a_s_rready = '0;
    #1 chk("t4_idle", a_s_rvalid, 2'b00);
    chk("t4_no_err", a_err, 0);
    b_m_rid = {2'd3, 16'h0}; b_m_rvalid = 1'b1; b_s_rready = '0;
    #1;
    chk("t6_rready", b_m_rready, 1);
    chk("t6_rvalid", b_s_rvalid, 3'b000);
    chk("t6_err_pre", b_err, 0);
    step();
    chk("t6_err", b_err, 1);
    b_m_rid = {2'd2, 16'h9};
    #1;
    chk("t6_route", b_s_rvalid, 3'b100);
    chk("t6_rid2", b_s_rid[47:32], 16'h9);
    chk("t6_rready_lo", b_m_rready, 0);
    b_s_rready = 3'b100;
    #1 chk("t6_rready_hi", b_m_rready, 1);
    b_m_rvalid = 1'b0;
    step();
    chk("t6_err_sticky", b_err, 1);
    rstb = 1'b1;
    #1 chk("t6_err_rst", b_err, 0);
    rstb = 1'b0;
    a_s_arvalid = 2'b10;
    step();
    chk("t7_busy", a_m_arvalid, 1);
    #2; a_m_arready = 1'b1; rst = 1'b1;
    #1;
    chk("t7_rst_arvalid", a_m_arvalid, 0);
    chk("t7_rst_arready", a_s_arready, 2'b00);
    step();
    rst = 1'b0; a_s_arvalid = 2'b01;
    step();
    chk("t7_cnt_cleared", {a_m_arvalid, a_m_arid[16]}, 2'b10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
